// File: rtl/snoop_bus_arbiter_pkg.sv
// Shared types for the snoop-bus arbiter: policy and FSM state encodings.
// Pure declarations; no latency or backpressure of its own.
package snoop_bus_arbiter_pkg;

   localparam int NUM_CPUS = 4;

   typedef enum logic {
      ARB_RR    = 1'b0,
      ARB_FIXED = 1'b1
   } arb_policy_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN  = 2'd1,
      TURN = 2'd2
   } arb_state_e;

endpackage

// File: rtl/snoop_bus_arbiter_rr_pick.sv
// Rotating-mask find-first: lowest set req bit at or above ptr, else lowest set bit overall.
// Purely combinational (0 cycles); no backpressure, found=0 when req is empty.
module snoop_bus_arbiter_rr_pick #(
   parameter int N = 4
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic                 found,
   output logic [$clog2(N)-1:0] idx
);

   localparam int IW = $clog2(N);

   logic [N-1:0]  mask;
   logic [N-1:0]  masked;
   logic [IW-1:0] lo_idx;
   logic [IW-1:0] hi_idx;
   logic          hi_hit;

   always_comb begin
      for (int i = 0; i < N; i++) begin
         mask[i] = (IW'(i) >= ptr);
      end
   end

   assign masked = req & mask;

   // Scan downward so the last hit written is the lowest index.
   always_comb begin
      lo_idx = '0;
      hi_idx = '0;
      hi_hit = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            lo_idx = IW'(i);
         end
         if (masked[i]) begin
            hi_idx = IW'(i);
            hi_hit = 1'b1;
         end
      end
   end

   assign found = |req;
   assign idx   = hi_hit ? hi_idx : lo_idx;

endmodule

// File: rtl/snoop_bus_arbiter.sv
// Snoop-bus owner arbiter (RR or fixed priority) with hold-timeout preemption and idle turnaround.
// Latency: req->gnt 1 cycle from IDLE; owners stall others by holding req/busy, preemption bounds the wait.
module snoop_bus_arbiter
   import snoop_bus_arbiter_pkg::*;
#(
   parameter int          NUM_REQ  = NUM_CPUS,
   parameter arb_policy_e POLICY   = ARB_RR,
   parameter int          MAX_HOLD = 16,
   parameter int          CNT_W    = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_REQ-1:0]         busy,
   output logic [NUM_REQ-1:0]         gnt,
   output logic                       gnt_valid,
   output logic [$clog2(NUM_REQ)-1:0] gnt_id,
   output logic                       contention,
   output logic                       preempt,
   output logic [NUM_REQ-1:0]         err_busy
);

   localparam int                 IW         = $clog2(NUM_REQ);
   localparam logic [NUM_REQ-1:0] ONE        = NUM_REQ'(1);
   localparam logic [CNT_W-1:0]   HOLD_MAX   = CNT_W'(MAX_HOLD);
   localparam logic [IW-1:0]      LAST_IDX   = IW'(NUM_REQ - 1);
   localparam bit                 PREEMPT_EN = (MAX_HOLD != 0);

   arb_state_e         state, state_nxt;
   logic [NUM_REQ-1:0] gnt_nxt;
   logic               gnt_valid_nxt;
   logic [IW-1:0]      gnt_id_nxt;
   logic [IW-1:0]      rr_ptr, rr_ptr_nxt;
   logic [CNT_W-1:0]   hold_cnt, hold_cnt_nxt;
   logic               contention_nxt;
   logic               preempt_nxt;
   logic [NUM_REQ-1:0] err_busy_nxt;

   logic               pick_found;
   logic [IW-1:0]      pick_idx;
   logic [IW-1:0]      pick_ptr;
   logic               multi_req;
   logic               owner_req;
   logic               owner_busy;
   logic               others_req;

   // Fixed priority is the rotating pick with the rotation pinned at index 0.
   assign pick_ptr = (POLICY == ARB_RR) ? rr_ptr : '0;

   snoop_bus_arbiter_rr_pick #(
      .N (NUM_REQ)
   ) u_rr_pick (
      .req   (req),
      .ptr   (pick_ptr),
      .found (pick_found),
      .idx   (pick_idx)
   );

   assign multi_req  = |(req & (req - ONE));
   assign owner_req  = |(req & gnt);
   assign owner_busy = |(busy & gnt);
   assign others_req = |(req & ~gnt);

   always_comb begin
      state_nxt      = state;
      gnt_nxt        = gnt;
      gnt_id_nxt     = gnt_id;
      rr_ptr_nxt     = rr_ptr;
      hold_cnt_nxt   = hold_cnt;
      contention_nxt = 1'b0;
      preempt_nxt    = 1'b0;
      err_busy_nxt   = busy & ~gnt;

      unique case (state)
         IDLE: begin
            if (pick_found) begin
               gnt_nxt        = ONE << pick_idx;
               gnt_id_nxt     = pick_idx;
               hold_cnt_nxt   = '0;
               contention_nxt = multi_req;
               state_nxt      = OWN;
               if (POLICY == ARB_RR) begin
                  rr_ptr_nxt = (pick_idx == LAST_IDX) ? '0 : pick_idx + IW'(1);
               end
            end
         end
         OWN: begin
            if (hold_cnt != HOLD_MAX) begin
               hold_cnt_nxt = hold_cnt + CNT_W'(1);
            end
            // Voluntary release wins over a coincident timeout.
            if (!owner_req && !owner_busy) begin
               gnt_nxt    = '0;
               gnt_id_nxt = '0;
               state_nxt  = TURN;
            end else if (PREEMPT_EN && (hold_cnt == HOLD_MAX) && !owner_busy && others_req) begin
               gnt_nxt     = '0;
               gnt_id_nxt  = '0;
               preempt_nxt = 1'b1;
               state_nxt   = TURN;
            end
         end
         TURN: begin
            gnt_nxt    = '0;
            gnt_id_nxt = '0;
            state_nxt  = IDLE;
         end
         default: begin
            gnt_nxt    = '0;
            gnt_id_nxt = '0;
            state_nxt  = IDLE;
         end
      endcase

      gnt_valid_nxt = |gnt_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         gnt        <= '0;
         gnt_valid  <= 1'b0;
         gnt_id     <= '0;
         rr_ptr     <= '0;
         hold_cnt   <= '0;
         contention <= 1'b0;
         preempt    <= 1'b0;
         err_busy   <= '0;
      end else begin
         state      <= state_nxt;
         gnt        <= gnt_nxt;
         gnt_valid  <= gnt_valid_nxt;
         gnt_id     <= gnt_id_nxt;
         rr_ptr     <= rr_ptr_nxt;
         hold_cnt   <= hold_cnt_nxt;
         contention <= contention_nxt;
         preempt    <= preempt_nxt;
         err_busy   <= err_busy_nxt;
      end
   end

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Directed bench for snoop_bus_arbiter: RR and fixed-priority instances, NUM_REQ=4, MAX_HOLD=4.
module tb_snoop_bus_arbiter;
   import snoop_bus_arbiter_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req_a, busy_a, gnt_a, err_a;
   logic [1:0] id_a;
   logic       vld_a, cont_a, pre_a;
   logic [3:0] req_b, busy_b, gnt_b, err_b;
   logic [1:0] id_b;
   logic       vld_b, cont_b, pre_b;

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;
   logic [3:0] prev_a = '0;
   logic [3:0] prev_b = '0;

   always #5 clk = ~clk;

   snoop_bus_arbiter #(.NUM_REQ(4), .POLICY(ARB_RR), .MAX_HOLD(4)) u_rr (
      .clk(clk), .rst(rst), .req(req_a), .busy(busy_a), .gnt(gnt_a), .gnt_valid(vld_a),
      .gnt_id(id_a), .contention(cont_a), .preempt(pre_a), .err_busy(err_a)
   );

   snoop_bus_arbiter #(.NUM_REQ(4), .POLICY(ARB_FIXED), .MAX_HOLD(4)) u_fx (
      .clk(clk), .rst(rst), .req(req_b), .busy(busy_b), .gnt(gnt_b), .gnt_valid(vld_b),
      .gnt_id(id_b), .contention(cont_b), .preempt(pre_b), .err_busy(err_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [1:0] id_of(input logic [3:0] g);
      logic [1:0] r;
      r = 2'd0;
      for (int i = 0; i < 4; i++) if (g[i]) r = 2'(i);
      return r;
   endfunction

   task automatic invariants();
      chk("inv_onehot_a", 32'($onehot0(gnt_a)), 1);
      chk("inv_valid_a", 32'(vld_a), 32'(|gnt_a));
      chk("inv_id_a", 32'(id_a), 32'(id_of(gnt_a)));
      if (prev_a != 4'd0 && gnt_a != 4'd0) chk("inv_gap_a", 32'(gnt_a), 32'(prev_a));
      prev_a = gnt_a;
      chk("inv_onehot_b", 32'($onehot0(gnt_b)), 1);
      chk("inv_valid_b", 32'(vld_b), 32'(|gnt_b));
      chk("inv_id_b", 32'(id_b), 32'(id_of(gnt_b)));
      if (prev_b != 4'd0 && gnt_b != 4'd0) chk("inv_gap_b", 32'(gnt_b), 32'(prev_b));
      prev_b = gnt_b;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      invariants();
   endtask

   initial begin
      logic [3:0] exp_g;
      rst = 1'b1; req_a = '0; busy_a = '0; req_b = '0; busy_b = '0;
      tick();
      tick();
      chk("rst_gnt", 32'(gnt_a), 0);
      chk("rst_vld", 32'(vld_a), 0);
      chk("rst_id", 32'(id_a), 0);
      chk("rst_cont", 32'(cont_a), 0);
      chk("rst_pre", 32'(pre_a), 0);
      chk("rst_err", 32'(err_a), 0);
      chk("rst_gnt_b", 32'(gnt_b), 0);
      rst = 1'b0;
      tick();
      chk("idle_gnt", 32'(gnt_a), 0);

      // Round-robin with all four requesting.
      req_a = 4'b1111;
      tick();
      chk("rr_first_gnt", 32'(gnt_a), 32'h1);
      chk("rr_first_cont", 32'(cont_a), 1);
      for (int k = 1; k <= 4; k++) begin
         req_a = 4'b1111 & ~gnt_a;
         tick();
         chk("rr_rel_gnt", 32'(gnt_a), 0);
         chk("rr_rel_cont", 32'(cont_a), 0);
         req_a = 4'b1111;
         tick();
         chk("rr_turn_gnt", 32'(gnt_a), 0);
         tick();
         exp_g = 4'b0001 << (k % 4);
         chk("rr_order_gnt", 32'(gnt_a), 32'(exp_g));
         chk("rr_order_id", 32'(id_a), 32'(k % 4));
         chk("rr_order_cont", 32'(cont_a), 1);
      end
      req_a = 4'b0000;
      tick();
      tick();
      chk("rr_drain_gnt", 32'(gnt_a), 0);

      // Preemption: owner 0 holds with busy=0 while 2 waits (rr_ptr=1).
      req_a = 4'b0001;
      tick();
      chk("pre_own0_gnt", 32'(gnt_a), 32'h1);
      chk("pre_single_cont", 32'(cont_a), 0);
      req_a = 4'b0101;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("pre_hold_gnt", 32'(gnt_a), 32'h1);
         chk("pre_hold_pre", 32'(pre_a), 0);
      end
      tick();
      chk("pre_drop_gnt", 32'(gnt_a), 0);
      chk("pre_pulse", 32'(pre_a), 1);
      tick();
      chk("pre_turn_gnt", 32'(gnt_a), 0);
      chk("pre_pulse_end", 32'(pre_a), 0);
      tick();
      chk("pre_next_gnt", 32'(gnt_a), 32'h4);
      chk("pre_next_id", 32'(id_a), 2);
      chk("pre_next_cont", 32'(cont_a), 1);

      // Busy blocks preemption (rr_ptr=3 -> owner 0 after wrap).
      req_a = 4'b0001;
      tick();
      tick();
      tick();
      chk("busy_own0_gnt", 32'(gnt_a), 32'h1);
      req_a = 4'b0101;
      busy_a = 4'b0001;
      for (int k = 0; k < 10; k++) begin
         tick();
         chk("busy_hold_gnt", 32'(gnt_a), 32'h1);
         chk("busy_hold_pre", 32'(pre_a), 0);
         chk("busy_owner_err", 32'(err_a), 0);
      end
      req_a = 4'b0100;
      busy_a = 4'b0000;
      tick();
      chk("busy_rel_gnt", 32'(gnt_a), 0);
      chk("busy_rel_nopre", 32'(pre_a), 0);
      tick();
      tick();
      chk("busy_next_gnt", 32'(gnt_a), 32'h4);
      chk("busy_next_cont", 32'(cont_a), 0);

      // Illegal busy from a non-owner (owner 1 via rr_ptr=3 wrap).
      req_a = 4'b0010;
      tick();
      tick();
      tick();
      chk("err_own1_gnt", 32'(gnt_a), 32'h2);
      busy_a = 4'b1000;
      tick();
      chk("err_pulse", 32'(err_a), 32'h8);
      chk("err_gnt_keep", 32'(gnt_a), 32'h2);
      busy_a = 4'b0000;
      tick();
      chk("err_clear", 32'(err_a), 0);
      chk("err_id_keep", 32'(id_a), 1);

      // Reset mid-OWN with owner 2, rr_ptr=3.
      req_a = 4'b0100;
      tick();
      tick();
      tick();
      chk("mrst_own2_gnt", 32'(gnt_a), 32'h4);
      rst = 1'b1;
      req_a = 4'b1111;
      tick();
      chk("mrst_gnt", 32'(gnt_a), 0);
      chk("mrst_id", 32'(id_a), 0);
      chk("mrst_vld", 32'(vld_a), 0);
      rst = 1'b0;
      tick();
      chk("mrst_first_gnt", 32'(gnt_a), 32'h1);
      chk("mrst_first_cont", 32'(cont_a), 1);
      req_a = 4'b0000;
      tick();
      tick();

      // Fixed priority: 1 always beats 3.
      req_b = 4'b1010;
      tick();
      chk("fx_first_gnt", 32'(gnt_b), 32'h2);
      chk("fx_first_cont", 32'(cont_b), 1);
      for (int k = 0; k < 3; k++) begin
         req_b = 4'b1000;
         tick();
         chk("fx_rel_gnt", 32'(gnt_b), 0);
         req_b = 4'b1010;
         tick();
         chk("fx_turn_gnt", 32'(gnt_b), 0);
         tick();
         chk("fx_win_gnt", 32'(gnt_b), 32'h2);
         chk("fx_win_id", 32'(id_b), 1);
      end
      req_b = 4'b1000;
      tick();
      tick();
      tick();
      chk("fx_alone_gnt", 32'(gnt_b), 32'h8);
      chk("fx_alone_cont", 32'(cont_b), 0);
      req_b = 4'b0000;
      tick();
      tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/snoop_bus_arbiter.md
Name: snoop_bus_arbiter

Overview:
Parametrised successor to the coherence-bus arbiter. Grants one of NUM_REQ cache controllers ownership of the snoop bus, with a compile-time policy of round-robin or fixed priority. Adds hold-timeout preemption, a mandatory idle turnaround cycle between owners, contention reporting and illegal-busy detection. Sits between the per-core caches (req/busy) and snoop_bus (gnt).

Parameters:
NUM_REQ, 4 (NUM_CPUS), number of requesters; legal range 2..16.
POLICY, ARB_RR, arbitration policy; ARB_RR is round-robin, ARB_FIXED gives lowest index the highest priority.
MAX_HOLD, 16, maximum cycles a non-busy owner may hold grant while others wait; 0 disables preemption.
CNT_W, $clog2(MAX_HOLD+1), hold counter width (derived, floor 1).

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req  in  NUM_REQ  per-requester bus request
busy  in  NUM_REQ  owner has a bus transaction in flight; meaningful only from the current owner
gnt  out  NUM_REQ  one-hot-or-zero grant, registered
gnt_valid  out  1  OR of gnt, registered
gnt_id  out  $clog2(NUM_REQ)  index of current owner; 0 when gnt_valid=0
contention  out  1  one-cycle pulse: more than one req seen at an arbitration decision
preempt  out  1  one-cycle pulse: grant revoked by timeout
err_busy  out  NUM_REQ  one-cycle pulse per bit: busy asserted by a non-owner

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, gnt=0, gnt_valid=0, gnt_id=0, rr_ptr=0, hold_cnt=0, all pulses 0. Applies mid-grant; no completion of the in-flight ownership.
- All outputs are registered. req to gnt latency is 1 cycle from IDLE.
- States: IDLE, OWN, TURN.
- IDLE: if req!=0, pick winner w, load gnt=onehot(w), gnt_id=w, hold_cnt=0, go to OWN. contention=1 if popcount(req)>1. Otherwise stay.
- Pick, ARB_RR: first set bit of req scanning from rr_ptr upward with wrap at NUM_REQ-1 to 0. ARB_FIXED: lowest set index.
- On every grant in ARB_RR mode, rr_ptr is set to (w+1) mod NUM_REQ, with an explicit wrap compare for non-power-of-2 NUM_REQ. rr_ptr is unused in ARB_FIXED.
- OWN: each cycle, hold_cnt increments and saturates at MAX_HOLD.
  - Release: if req[w]=0 and busy[w]=0, clear gnt and go to TURN.
  - Preempt: if MAX_HOLD!=0, hold_cnt==MAX_HOLD, busy[w]=0, and (req & ~onehot(w))!=0, clear gnt, pulse preempt, and go to TURN.
  - busy[w]=1 always blocks preemption, regardless of hold_cnt.
  - Release takes precedence over preempt in the same cycle; preempt is not pulsed.
- TURN: gnt=0 for exactly one cycle so the bus is idle between owners, then go to IDLE. Arbitration happens in IDLE, so the minimum gap between owners is 2 cycles of gnt=0.
- A preempted requester keeping req high re-competes normally. In RR it is now lowest priority.
- err_busy[i] pulses in any cycle where busy[i]=1 and i is not the current owner (including in IDLE/TURN). The arbiter otherwise ignores it.
- busy[w] with req[w]=0 keeps ownership (transaction draining).
- Invariants (bench asserts): $onehot0(gnt); gnt_valid==|gnt; gnt_id matches gnt; gnt never changes owner without at least one gnt=0 cycle.

Decomposition:
- Shared types package gets: enum arb_policy_e {ARB_RR, ARB_FIXED}; enum arb_state_e {IDLE, OWN, TURN}; NUM_CPUS remains the source for the NUM_REQ default.
- One sub-module: rr_pick, a combinational rotating-mask find-first. Inputs req and ptr; outputs found and idx. ARB_FIXED instantiates it with ptr tied to 0.

Test Plan:
- NUM_REQ=4, RR. req=4'b1111 held, busy=0, each owner drops req 1 cycle after gnt. Required: grant order 0,1,2,3,0; contention pulses on each decision; 2-cycle gnt=0 gap between owners.
- ARB_FIXED. req=4'b1010 repeatedly. Required: owner 1 always wins; 3 is never granted while req[1] reasserts in IDLE.
- MAX_HOLD=4. Owner 0 holds req with busy=0, req[2]=1. Required: gnt[0] drops after 5 OWN cycles, preempt=1 for one cycle, gnt[2] 2 cycles later.
- Same setup as the preempt case, but busy[0]=1 for 10 cycles. Required: no preempt; release once req[0]=busy[0]=0; then owner 2.
- busy[3]=1 while owner is 1. Required: err_busy=4'b1000 pulse; gnt unchanged.
- rst=1 mid-OWN (owner 2, rr_ptr=3). Required: next cycle gnt=0, gnt_id=0; with req=4'b1111 after reset the first grant goes to 0.
